uart_cmd_parser: RTL and testbench

Byte-level command parser between the UART receiver and the target-position registers inside `uart_top`. It assembles 5-byte host frames, checks them, and writes the two target positions to shadow registers. The shadow registers are copied to `target_pos_out1`/`target_pos_out2` on the next VSYNC falling edge, so the pixel pipeline never sees a mid-frame change. It returns one ACK/NAK byte per frame to the UART transmitter.

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_timeout.sv | 34 +++
 rtl/uart_cmd_parser.sv | 164 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command parser.
// Holds the parser FSM encoding, the default frame byte values and the
// frame checksum helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_OK  = 3'd1,
    S_GOT_CMD = 3'd2,
    S_GOT_P1  = 3'd3,
    S_GOT_P2  = 3'd4,
    S_RESP    = 3'd5
  } cmd_state_t;

  localparam logic [7:0] DEF_HEADER      = 8'h55;
  localparam logic [7:0] DEF_CMD_SET_POS = 8'h01;
  localparam logic [7:0] DEF_ACK_BYTE    = 8'hAA;
  localparam logic [7:0] DEF_NAK_BYTE    = 8'hEE;

  // Frame checksum: XOR of command and both payload bytes.
  function automatic logic [7:0] calc_chk(input logic [7:0] cmd,
                                          input logic [7:0] p1,
                                          input logic [7:0] p2);
    return cmd ^ p1 ^ p2;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte idle counter for the command parser.
// Counts cycles while run is high; any clear (a received byte) or a drop of
// run restarts it. expired is high for the cycle the count sits at the
// limit, which the parser sees for exactly one cycle because it leaves the
// running states in response.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  // Idle counter: restart on a byte or outside a frame, saturate at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && !clear && (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte host frames (HEADER CMD P1 P2 CHK),
// loads good SET_POS payloads into shadow registers and applies them to the
// target position outputs on the next VSYNC falling edge.
// Build option: define UART_CMD_ACK_EN to return an ACK/NAK byte per frame
// through tx_data/tx_valid/tx_ready; without it the response port is idle.
//
// Response handshake: tx_valid rises with tx_data the cycle after the CHK
// byte, both stay stable while tx_ready is low, and the byte is transferred
// on a cycle where tx_valid && tx_ready; tx_valid drops the cycle after.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEF_HEADER,
  parameter logic [7:0] CMD_SET_POS    = DEF_CMD_SET_POS,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [1:0] r_vsync_i,
  output logic [7:0] target_pos_out1,
  output logic [7:0] target_pos_out2,
  output logic       pos_pending,
  output logic       frame_err,
  output logic [2:0] dbg_state
);

  cmd_state_t state;
  logic [7:0] cmd_q;
  logic [7:0] p1_q;
  logic [7:0] p2_q;
  logic [7:0] shadow1;
  logic [7:0] shadow2;
  logic       timeout_run;
  logic       timeout_expired;
  logic       frame_good;
  logic       vsync_fall;

  assign dbg_state   = state;
  assign vsync_fall  = (r_vsync_i == 2'b10);
  assign timeout_run = (state == S_HDR_OK) || (state == S_GOT_CMD) ||
                       (state == S_GOT_P1) || (state == S_GOT_P2);
  assign frame_good  = (rx_data == calc_chk(cmd_q, p1_q, p2_q)) &&
                       (cmd_q == CMD_SET_POS);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .run    (timeout_run),
    .expired(timeout_expired)
  );

`ifndef UART_CMD_ACK_EN
  // Response port is idle in this build; tx_ready is intentionally unused.
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_data  = 8'h00;
  assign tx_valid = 1'b0;
`endif

  // Parser FSM with registered outputs; the VSYNC apply happens before the
  // frame update so a same-cycle good CHK leaves its new values pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cmd_q           <= 8'h00;
      p1_q            <= 8'h00;
      p2_q            <= 8'h00;
      shadow1         <= 8'h00;
      shadow2         <= 8'h00;
      target_pos_out1 <= 8'h00;
      target_pos_out2 <= 8'h00;
      pos_pending     <= 1'b0;
      frame_err       <= 1'b0;
`ifdef UART_CMD_ACK_EN
      tx_data         <= 8'h00;
      tx_valid        <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;

      if (vsync_fall && pos_pending) begin
        target_pos_out1 <= shadow1;
        target_pos_out2 <= shadow2;
        pos_pending     <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == HEADER)) state <= S_HDR_OK;
        end
        S_HDR_OK: begin
          if (timeout_expired) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
          end else if (rx_valid) begin
            cmd_q <= rx_data;
            state <= S_GOT_CMD;
          end
        end
        S_GOT_CMD: begin
          if (timeout_expired) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
          end else if (rx_valid) begin
            p1_q  <= rx_data;
            state <= S_GOT_P1;
          end
        end
        S_GOT_P1: begin
          if (timeout_expired) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
          end else if (rx_valid) begin
            p2_q  <= rx_data;
            state <= S_GOT_P2;
          end
        end
        S_GOT_P2: begin
          if (timeout_expired) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
          end else if (rx_valid) begin
            if (frame_good) begin
              shadow1     <= p1_q;
              shadow2     <= p2_q;
              pos_pending <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
`ifdef UART_CMD_ACK_EN
            tx_data  <= frame_good ? ACK_BYTE : NAK_BYTE;
            tx_valid <= 1'b1;
            state    <= S_RESP;
`else
            state    <= S_IDLE;
`endif
          end
        end
        S_RESP: begin
`ifdef UART_CMD_ACK_EN
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed bench for uart_cmd_parser (TIMEOUT_CYCLES=50).
// Works for both builds: with UART_CMD_ACK_EN the response bytes are checked
// against the expected queue, otherwise the response port must stay idle.
module tb_uart_cmd_parser;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] r_vsync_i;
  logic [7:0] target_pos_out1;
  logic [7:0] target_pos_out2;
  logic       pos_pending;
  logic       frame_err;
  logic [2:0] dbg_state;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .r_vsync_i      (r_vsync_i),
    .target_pos_out1(target_pos_out1),
    .target_pos_out2(target_pos_out2),
    .pos_pending    (pos_pending),
    .frame_err      (frame_err),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: one byte strobe, changed only on falling edges.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends the CHK byte together with a VSYNC falling edge.
  task automatic send_byte_with_fall(input logic [7:0] b);
    @(negedge clk);
    rx_data   = b;
    rx_valid  = 1'b1;
    r_vsync_i = 2'b10;
    @(negedge clk);
    rx_valid  = 1'b0;
    r_vsync_i = 2'b00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] chk,
                            input logic [7:0] exp_resp);
    exp_q.push_back(exp_resp);
    send_byte(8'h55);
    send_byte(c);
    send_byte(p1);
    send_byte(chk == 8'hxx ? 8'h00 : p2);
    send_byte(chk);
  endtask

  task automatic vsync_fall;
    @(negedge clk);
    r_vsync_i = 2'b10;
    @(negedge clk);
    r_vsync_i = 2'b00;
  endtask

  // Called right after the CHK byte (one cycle after it was sampled).
  task automatic check_resp(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
`ifdef UART_CMD_ACK_EN
    check({tag, "_tx_valid"}, tx_valid, 1);
    check({tag, "_tx_data"}, tx_data, exp);
    if (tx_ready) begin
      @(negedge clk);
      check({tag, "_tx_drop"}, tx_valid, 0);
    end
`else
    check({tag, "_tx_idle"}, {tx_valid, tx_data}, {1'b0, 8'h00});
    if (exp == 8'h00) check({tag, "_tx_exp"}, 0, 1);
`endif
  endtask

  initial begin
    int n;
    bit seen_err;
    bit seen_tx;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b1;
    r_vsync_i = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_out1", target_pos_out1, 8'h00);
    check("rst_out2", target_pos_out2, 8'h00);
    check("rst_pending", pos_pending, 0);
    check("rst_tx", {tx_valid, tx_data}, 9'h000);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    @(negedge clk);

    // Good frame: 55 01 3C 7F 42
    send_frame(8'h01, 8'h3C, 8'h7F, 8'h42, 8'hAA);
    check("good_pending", pos_pending, 1);
    check("good_err", frame_err, 0);
    check("good_out_held", {target_pos_out1, target_pos_out2}, 16'h0000);
    check_resp("good");
    vsync_fall();
    check("good_apply", {target_pos_out1, target_pos_out2}, 16'h3C7F);
    check("good_pending_clr", pos_pending, 0);

    // Bad checksum: 55 01 11 22 00
    send_frame(8'h01, 8'h11, 8'h22, 8'h00, 8'hEE);
    check("bad_err", frame_err, 1);
    check("bad_pending", pos_pending, 0);
    check_resp("bad");
    @(negedge clk);
    check("bad_err_pulse", frame_err, 0);
    vsync_fall();
    check("bad_out", {target_pos_out1, target_pos_out2}, 16'h3C7F);

    // Unknown command with a matching checksum: 55 02 3C 7F 41
    send_frame(8'h02, 8'h3C, 8'h7F, 8'h41, 8'hEE);
    check("badcmd_err", frame_err, 1);
    check_resp("badcmd");

    // Leading junk, then a good frame under back-pressure: 55 01 5A 66 3D
    tx_ready = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(8'h01, 8'h5A, 8'h66, 8'h3D, 8'hAA);
    check_resp("bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifdef UART_CMD_ACK_EN
      check("bp_hold", {tx_valid, tx_data}, {1'b1, 8'hAA});
`else
      check("bp_idle", tx_valid, 0);
`endif
    end
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released", tx_valid, 0);
    check("bp_pending", pos_pending, 1);
    vsync_fall();
    check("bp_apply", {target_pos_out1, target_pos_out2}, 16'h5A66);

    // Timeout after 55 01
    send_byte(8'h55);
    send_byte(8'h01);
    n = 0;
    seen_err = 0;
    seen_tx = 0;
    while (!seen_err && n < 200) begin
      if (frame_err) seen_err = 1;
      else begin
        if (tx_valid) seen_tx = 1;
        @(negedge clk);
        n++;
      end
    end
    check("to_seen", seen_err, 1);
    check("to_window", (n >= 45 && n <= 60), 1);
    check("to_no_tx", seen_tx, 0);
    @(negedge clk);
    check("to_state", dbg_state, 0);
    send_frame(8'h01, 8'h3C, 8'h7F, 8'h42, 8'hAA);
    check("to_next_pending", pos_pending, 1);
    check_resp("to_next");
    vsync_fall();
    check("to_next_apply", {target_pos_out1, target_pos_out2}, 16'h3C7F);

    // Edge race: pending 10/20, second frame AA/BB with CHK on the fall.
    send_frame(8'h01, 8'h10, 8'h20, 8'h31, 8'hAA);
    check_resp("race1");
    exp_q.push_back(8'hAA);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte_with_fall(8'h10);
    check("race_apply_old", {target_pos_out1, target_pos_out2}, 16'h1020);
    check("race_pending", pos_pending, 1);
    check_resp("race2");
    vsync_fall();
    check("race_apply_new", {target_pos_out1, target_pos_out2}, 16'hAABB);
    check("race_pending_clr", pos_pending, 0);

    // Reset mid-frame, then a clean frame.
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h3C);
    reset = 1'b0;
    #1;
    check("midrst_out", {target_pos_out1, target_pos_out2}, 16'h0000);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b1;
    send_frame(8'h01, 8'h3C, 8'h7F, 8'h42, 8'hAA);
    check("midrst_pending", pos_pending, 1);
    check("midrst_err", frame_err, 0);
    check_resp("midrst");
    vsync_fall();
    check("midrst_apply", {target_pos_out1, target_pos_out2}, 16'h3C7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
